// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibits the clock, issues a request-to-send,
// shifts data/parity/stop on device-generated falling edges and checks the device ACK.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 1500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       err
);
    localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES + 1) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [IW-1:0] INH_PRE  = IW'((INHIBIT_CYCLES > 1) ? INHIBIT_CYCLES - 2 : 0);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE
    } state_t;

    state_t        state;
    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic [3:0]    clk_hist;
    logic          clk_filt;
    logic          fall;
    logic [9:0]    frame;
    logic [3:0]    bit_idx;
    logic [3:0]    bit_nxt;
    logic [IW-1:0] inh_cnt;
    logic [TW-1:0] to_cnt;
    logic          to_run;

    // Synchronizers and 4-sample clock filter; an edge is the filtered 1->0 step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
            clk_hist <= 4'hF;
            clk_filt <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk_i;
            clk_s2   <= clk_s1;
            dat_s1   <= ps2_data_i;
            dat_s2   <= dat_s1;
            clk_hist <= {clk_hist[2:0], clk_s2};
            if (clk_hist == 4'hF)
                clk_filt <= 1'b1;
            else if (clk_hist == 4'h0)
                clk_filt <= 1'b0;
        end
    end

    assign fall    = clk_filt & (clk_hist == 4'h0);
    assign bit_nxt = bit_idx + 4'd1;
    assign to_run  = (state == REQ) || (state == SHIFT) || (state == ACK) || (state == WAIT_IDLE);
    assign busy    = (state != IDLE);

    // Frame is {stop, odd parity, d7..d0}; only captured when a request is accepted.
    always_ff @(posedge clk) begin
        if (state == IDLE && tx_start)
            frame <= {1'b1, ~^tx_data, tx_data};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            inh_cnt     <= '0;
            to_cnt      <= '0;
            bit_idx     <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (to_run && to_cnt == TO_LAST) begin
                // Timeout wins over any edge arriving in the same cycle.
                err         <= 1'b1;
                ps2_clk_oe  <= 1'b0;
                ps2_data_oe <= 1'b0;
                state       <= IDLE;
            end else begin
                if (to_run)
                    to_cnt <= to_cnt + TW'(1);
                case (state)
                    IDLE: begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        if (tx_start) begin
                            state       <= INHIBIT;
                            ps2_clk_oe  <= 1'b1;
                            ps2_data_oe <= (INHIBIT_CYCLES <= 1);
                            inh_cnt     <= '0;
                        end
                    end
                    INHIBIT: begin
                        inh_cnt <= inh_cnt + IW'(1);
                        if (inh_cnt == INH_LAST) begin
                            state       <= REQ;
                            ps2_clk_oe  <= 1'b0;
                            ps2_data_oe <= 1'b1;
                            to_cnt      <= '0;
                        end else if (INHIBIT_CYCLES > 1 && inh_cnt == INH_PRE) begin
                            ps2_data_oe <= 1'b1;
                        end
                    end
                    REQ: begin
                        if (fall) begin
                            state       <= SHIFT;
                            bit_idx     <= '0;
                            ps2_data_oe <= ~frame[0];
                        end
                    end
                    SHIFT: begin
                        // bit_idx names the frame bit currently on the line.
                        if (fall) begin
                            ps2_data_oe <= ~frame[bit_nxt];
                            bit_idx     <= bit_nxt;
                            if (bit_nxt == 4'd9)
                                state <= ACK;
                        end
                    end
                    ACK: begin
                        if (fall) begin
                            if (!dat_s2) begin
                                state <= WAIT_IDLE;
                            end else begin
                                err         <= 1'b1;
                                ps2_data_oe <= 1'b0;
                                state       <= IDLE;
                            end
                        end
                    end
                    WAIT_IDLE: begin
                        if (clk_filt && dat_s2) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state       <= IDLE;
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-collector PS/2 device model.
module tb_ps2_host_tx;
    localparam int INH = 100;
    localparam int TO  = 3000;
    localparam int H   = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2_clk_i, ps2_data_i;
    logic       ps2_clk_oe, ps2_data_oe, busy, done, err;

    int checks = 0;
    int errors = 0;
    int n_done = 0;
    int n_err  = 0;
    int n_both = 0;

    assign ps2_clk_i  = dev_clk  & ~ps2_clk_oe;
    assign ps2_data_i = dev_data & ~ps2_data_oe;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_start(tx_start),
        .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) n_done++;
        if (err === 1'b1) n_err++;
        if (done === 1'b1 && err === 1'b1) n_both++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Counts negedge samples with clock inhibited, and those also showing data pulled.
    task automatic measure_inhibit(output int hi, output int both);
        int g = 0;
        hi = 0;
        both = 0;
        while (ps2_clk_oe === 1'b1 && g < 1000) begin
            hi++;
            if (ps2_data_oe === 1'b1) both++;
            @(negedge clk);
            g++;
        end
    endtask

    task automatic dev_frame(input int nedges, input logic ack, input logic glitch,
                             input logic poke, output logic [9:0] got, output logic start_ok);
        got = '0;
        start_ok = (ps2_data_i === 1'b0) && (ps2_clk_oe === 1'b0);
        repeat (H) @(negedge clk);
        for (int k = 1; k <= nedges; k++) begin
            if (k == 11) dev_data = ack ? 1'b0 : 1'b1;
            dev_clk = 1'b0;
            if (glitch && k >= 3 && k <= 7) begin
                repeat (8) @(negedge clk);
                dev_clk = 1'b1;
                @(negedge clk);
                dev_clk = 1'b0;
                repeat (H - 9) @(negedge clk);
            end else begin
                repeat (H) @(negedge clk);
            end
            if (poke && k == 4) begin
                tx_data  = 8'h00;
                tx_start = 1'b1;
                @(negedge clk);
                tx_start = 1'b0;
            end
            dev_clk = 1'b1;
            if (k <= 10) got[k-1] = ps2_data_i;
            if (k == 11) begin
                dev_data = 1'b1;
            end else if (glitch && k >= 3 && k <= 7) begin
                repeat (8) @(negedge clk);
                dev_clk = 1'b0;
                repeat (2) @(negedge clk);
                dev_clk = 1'b1;
                repeat (H - 10) @(negedge clk);
            end else begin
                repeat (H) @(negedge clk);
            end
        end
    endtask

    task automatic wait_end(output logic sd, output logic se);
        int g = 0;
        while (done !== 1'b1 && err !== 1'b1 && g < 200) begin
            @(negedge clk);
            g++;
        end
        sd = done;
        se = err;
    endtask

    initial begin
        int hi, both, cyc, d0, e0;
        logic [9:0] got;
        logic so, sd, se;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_clk_oe", ps2_clk_oe, 0);
        chk("rst_data_oe", ps2_data_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done_err", {done, err}, 0);
        rst = 1'b1;
        repeat (10) @(negedge clk);

        // 0xED, device ACKs
        tx_data = 8'hED; tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        chk("ed_busy", busy, 1);
        measure_inhibit(hi, both);
        chk("ed_inhibit_len", hi, INH);
        chk("ed_data_in_last_inh", both, 1);
        dev_frame(11, 1'b1, 1'b0, 1'b0, got, so);
        chk("ed_start_bit", so, 1);
        chk("ed_frame", got, 10'h3ED);
        wait_end(sd, se);
        chk("ed_done_err", {sd, se}, 2'b10);
        chk("ed_busy_after", busy, 0);

        // 0xF4 requested in the cycle of the done pulse
        tx_data = 8'hF4; tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        chk("f4_busy", busy, 1);
        measure_inhibit(hi, both);
        chk("f4_inhibit_len", hi, INH);
        dev_frame(11, 1'b1, 1'b0, 1'b0, got, so);
        chk("f4_frame", got, 10'h2F4);
        wait_end(sd, se);
        chk("f4_done_err", {sd, se}, 2'b10);

        // 0xA5 with clock glitches
        @(negedge clk);
        tx_data = 8'hA5; tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        measure_inhibit(hi, both);
        dev_frame(11, 1'b1, 1'b1, 1'b0, got, so);
        chk("a5_glitch_frame", got, 10'h3A5);
        wait_end(sd, se);
        chk("a5_done_err", {sd, se}, 2'b10);

        // 0x81 with a new request of 0x00 during shifting
        @(negedge clk);
        tx_data = 8'h81; tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        measure_inhibit(hi, both);
        dev_frame(11, 1'b1, 1'b0, 1'b1, got, so);
        chk("81_poke_frame", got, 10'h381);
        wait_end(sd, se);
        chk("81_done_err", {sd, se}, 2'b10);
        repeat (5) @(negedge clk);
        chk("81_idle_after_poke", busy, 0);

        // 0x12, device leaves data high at the 11th edge
        d0 = n_done; e0 = n_err;
        tx_data = 8'h12; tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        measure_inhibit(hi, both);
        dev_frame(11, 1'b0, 1'b0, 1'b0, got, so);
        chk("12_frame", got, 10'h312);
        repeat (10) @(negedge clk);
        chk("noack_err_cnt", n_err - e0, 1);
        chk("noack_done_cnt", n_done - d0, 0);
        chk("noack_idle", {busy, ps2_clk_oe, ps2_data_oe}, 0);

        // Device never clocks: timeout
        d0 = n_done;
        tx_data = 8'h55; tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        measure_inhibit(hi, both);
        cyc = 0;
        while (err !== 1'b1 && cyc < TO + 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("timeout_cycles", cyc, TO);
        chk("timeout_lines", {ps2_clk_oe, ps2_data_oe}, 0);
        chk("timeout_no_done", n_done - d0, 0);
        @(negedge clk);
        chk("timeout_err_one_cycle", err, 0);
        chk("timeout_busy", busy, 0);

        // Reset in the middle of shifting 0x30 (d3 = 0 on the line)
        d0 = n_done; e0 = n_err;
        tx_data = 8'h30; tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        measure_inhibit(hi, both);
        dev_frame(4, 1'b1, 1'b0, 1'b0, got, so);
        chk("mid_data_pulled", ps2_data_oe, 1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_lines", {ps2_clk_oe, ps2_data_oe}, 0);
        chk("mid_rst_busy", busy, 0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (60) @(negedge clk);
        chk("mid_rst_no_pulse", {n_done - d0, n_err - e0}, 0);
        chk("mid_rst_idle", busy, 0);

        chk("total_done", n_done, 4);
        chk("total_err", n_err, 2);
        chk("done_err_overlap", n_both, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 The block SHALL have parameter INHIBIT_CYCLES, default 10000, giving the clock-inhibit hold time (100 us at 100 MHz).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 1500000, giving the maximum request-to-ACK time (15 ms at 100 MHz).
REQ-003 The block SHALL have port clk  input  1  system clock, all state on its rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous active-low reset (0 = reset).
REQ-005 The block SHALL have port tx_data  input  8  byte to transmit to the PS/2 device.
REQ-006 The block SHALL have port tx_start  input  1  request to send tx_data, sampled each cycle.
REQ-007 The block SHALL have port ps2_clk_i  input  1  raw PS/2 clock line level (asynchronous).
REQ-008 The block SHALL have port ps2_data_i  input  1  raw PS/2 data line level (asynchronous).
REQ-009 The block SHALL have port ps2_clk_oe  output  1  1 = pull PS/2 clock low, 0 = release (open collector).
REQ-010 The block SHALL have port ps2_data_oe  output  1  1 = pull PS/2 data low, 0 = release.
REQ-011 The block SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-012 The block SHALL have port done  output  1  one-cycle pulse on device ACK received.
REQ-013 The block SHALL have port err  output  1  one-cycle pulse on timeout or missing ACK.

Function
REQ-014 ps2_clk_i and ps2_data_i SHALL each pass a 2-FF synchronizer; the synchronized clock SHALL pass a filter that updates only after 4 consecutive equal samples; a falling edge is a filtered 1->0 transition.
REQ-015 States SHALL be IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE.
REQ-016 IDLE: outputs released; tx_start=1 SHALL latch tx_data and compute odd parity (~^tx_data), then enter INHIBIT next cycle.
REQ-017 tx_start SHALL be ignored in every state except IDLE, with no effect on the latched byte.
REQ-018 INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles; ps2_data_oe SHALL assert in the final INHIBIT cycle.
REQ-019 REQ: ps2_clk_oe=0, ps2_data_oe=1 (start bit); the timeout counter SHALL clear on entry; the first falling edge SHALL enter SHIFT with bit index 0.
REQ-020 SHIFT: on each falling edge, ps2_data_oe SHALL become ~bit: edges 1-8 present d0..d7 (LSB first), edge 9 parity, edge 10 releases data (stop=1); edge 10 SHALL enter ACK.
REQ-021 ACK: on the next falling edge, synchronized ps2_data_i=0 SHALL enter WAIT_IDLE; ps2_data_i=1 SHALL pulse err and enter IDLE.
REQ-022 WAIT_IDLE: when filtered clock=1 and synchronized data=1, done SHALL pulse and the state SHALL return to IDLE in the same cycle.
REQ-023 The timeout counter SHALL run in REQ, SHIFT, ACK and WAIT_IDLE; on reaching TIMEOUT_CYCLES it SHALL pulse err, release both lines and enter IDLE, overriding any simultaneous edge.
REQ-024 A tx_start in the cycle after done/err (state IDLE) SHALL be accepted normally.
REQ-025 done and err SHALL never assert together, and each SHALL last one cycle.
REQ-026 Implementations SHALL use counters wide enough for the parameters; counters SHALL not wrap.

Reset
REQ-027 rst=0 SHALL immediately force IDLE, ps2_clk_oe=0, ps2_data_oe=0, busy=0, done=0, err=0, and clear the counters, synchronizers (to 1) and the filter (to 1).
REQ-028 Reset mid-transfer SHALL release both lines within the reset assertion, with no done/err pulse after release.

Verification
REQ-029 Device model ACKs a 0xED transfer -> data bits 1,0,1,1,0,1,1,1, parity 1, stop released, one done pulse, busy low.
REQ-030 Device model ACKs a 0xF4 transfer -> parity bit 0; ps2_clk_oe high for exactly 10000 cycles before release.
REQ-031 Device never clocks after request -> err pulses 1500000 cycles after REQ entry; lines released; no done.
REQ-032 Device leaves data high at the 11th edge -> err pulse, IDLE, no done.
REQ-033 1-2 cycle glitches on ps2_clk_i during SHIFT -> no extra bit shift; byte 0xA5 still transmits correctly.
REQ-034 tx_start pulsed during SHIFT with new data 0x00 -> ignored; original byte completes; rst=0 mid-SHIFT -> both oe=0 immediately.
